round_controller: RTL and testbench

//  Sequences each Tron round under the game-state FSM. Runs a pre-round countdown,

---
 rtl/tron_pkg.sv | 33 +++
 rtl/frame_counter.sv | 30 +++
 rtl/round_controller.sv | 165 ++++++++++++++++
 tb/tb_round_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared Tron types: game-state encoding, round-controller states, score width
// and the HUD countdown helper.
package tron_pkg;

  typedef enum logic [2:0] {
    Menu          = 3'd0,
    Round_Paused  = 3'd1,
    Round_Started = 3'd2,
    Blue_Wins     = 3'd3,
    Red_Wins      = 3'd4
  } game_state_t;

  typedef enum logic [2:0] {
    RC_IDLE      = 3'd0,
    RC_COUNTDOWN = 3'd1,
    RC_PLAY      = 3'd2,
    RC_ROUND_END = 3'd3,
    RC_MATCH_END = 3'd4
  } rc_state_t;

  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 12;

  // Whole seconds left for the HUD: ceil(cnt*3/total).
  function automatic logic [1:0] countdown_sec(input logic [FRAME_CNT_W-1:0] cnt,
                                               input int total);
    int secs;
    secs = 0;
    if (total > 0) secs = (int'(cnt) * 3 + total - 1) / total;
    return 2'(secs);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable frame down-counter; expire flags that the count is zero or reaches
// zero on this tick. Load takes priority over the tick.
module frame_counter
  import tron_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] load_val,
  input  logic                   tick,
  output logic [FRAME_CNT_W-1:0] cnt_nxt,
  output logic                   expire
);

  logic [FRAME_CNT_W-1:0] cnt;

  always_comb begin
    cnt_nxt = cnt;
    if (load) cnt_nxt = load_val;
    else if (tick && cnt != '0) cnt_nxt = cnt - FRAME_CNT_W'(1);
  end

  assign expire = (cnt == '0) || (tick && cnt == FRAME_CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/round_controller.sv
// Tron round sequencer: countdown, movement gating, crash scoring, round reset.
// Optional round timeout enabled by defining ROUND_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for Game_State == Round_Started
// COUNTDOWN  | pre-round countdown, crashes ignored
// PLAY       | cycles move, crashes scored
// ROUND_END  | crash scene held, then Reset_Round pulse
// MATCH_END  | winner flag held until Game_State leaves Round_Started
module round_controller
  import tron_pkg::*;
#(
  parameter int COUNT_FRAMES   = 180,
  parameter int END_FRAMES     = 90,
  parameter int WIN_SCORE      = 3,
  parameter int TIMEOUT_FRAMES = 3600
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Frame_Tick,
  input  logic [2:0]         Game_State,
  input  logic               Blue_Crash,
  input  logic               Red_Crash,
  output logic               Move_En,
  output logic               Reset_Round,
  output logic               Blue_W,
  output logic               Red_W,
  output logic [SCORE_W-1:0] Blue_Score,
  output logic [SCORE_W-1:0] Red_Score,
  output logic [1:0]         Countdown
);

  localparam logic [2:0] ST_IDLE      = RC_IDLE;
  localparam logic [2:0] ST_COUNTDOWN = RC_COUNTDOWN;
  localparam logic [2:0] ST_PLAY      = RC_PLAY;
  localparam logic [2:0] ST_ROUND_END = RC_ROUND_END;
  localparam logic [2:0] ST_MATCH_END = RC_MATCH_END;

  localparam logic [2:0] GS_MENU    = Menu;
  localparam logic [2:0] GS_STARTED = Round_Started;

  logic [2:0]             state, state_nxt;
  logic                   blue_won, blue_won_nxt;
  logic [SCORE_W-1:0]     blue_nxt, red_nxt, blue_inc, red_inc;
  logic                   rr_nxt, in_round;
  logic                   cnt_load, cnt_expire;
  logic [FRAME_CNT_W-1:0] cnt_load_val, cnt_nxt;

  assign in_round = (Game_State == GS_STARTED);
  assign blue_inc = Blue_Score + SCORE_W'(1);
  assign red_inc  = Red_Score + SCORE_W'(1);

  frame_counter u_frame_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (Frame_Tick),
    .cnt_nxt  (cnt_nxt),
    .expire   (cnt_expire)
  );

  always_comb begin
    state_nxt    = state;
    blue_won_nxt = blue_won;
    blue_nxt     = Blue_Score;
    red_nxt      = Red_Score;
    rr_nxt       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (in_round) begin
          state_nxt    = ST_COUNTDOWN;
          cnt_load     = 1'b1;
          cnt_load_val = FRAME_CNT_W'(COUNT_FRAMES);
        end
      end
      ST_COUNTDOWN: begin
        if (!in_round) state_nxt = ST_IDLE;
        else if (cnt_expire) begin
          // Timeout is loaded unconditionally; it only matters with the timeout built in.
          state_nxt    = ST_PLAY;
          cnt_load     = 1'b1;
          cnt_load_val = FRAME_CNT_W'(TIMEOUT_FRAMES);
        end
      end
      ST_PLAY: begin
        if (!in_round) state_nxt = ST_IDLE;
        else if (Blue_Crash && Red_Crash) begin
          state_nxt    = ST_ROUND_END;
          cnt_load     = 1'b1;
          cnt_load_val = FRAME_CNT_W'(END_FRAMES);
        end else if (Blue_Crash) begin
          red_nxt = red_inc;
          if (red_inc == SCORE_W'(WIN_SCORE)) begin
            state_nxt    = ST_MATCH_END;
            blue_won_nxt = 1'b0;
          end else begin
            state_nxt    = ST_ROUND_END;
            cnt_load     = 1'b1;
            cnt_load_val = FRAME_CNT_W'(END_FRAMES);
          end
        end else if (Red_Crash) begin
          blue_nxt = blue_inc;
          if (blue_inc == SCORE_W'(WIN_SCORE)) begin
            state_nxt    = ST_MATCH_END;
            blue_won_nxt = 1'b1;
          end else begin
            state_nxt    = ST_ROUND_END;
            cnt_load     = 1'b1;
            cnt_load_val = FRAME_CNT_W'(END_FRAMES);
          end
        end
`ifdef ROUND_TIMEOUT_EN
        else if (cnt_expire) begin
          state_nxt    = ST_ROUND_END;
          cnt_load     = 1'b1;
          cnt_load_val = FRAME_CNT_W'(END_FRAMES);
        end
`endif
      end
      ST_ROUND_END: begin
        if (!in_round) state_nxt = ST_IDLE;
        else if (cnt_expire) begin
          state_nxt = ST_IDLE;
          rr_nxt    = 1'b1;
        end
      end
      ST_MATCH_END: begin
        if (!in_round) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (Game_State == GS_MENU) begin
      blue_nxt = '0;
      red_nxt  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      blue_won    <= 1'b0;
      Move_En     <= 1'b0;
      Reset_Round <= 1'b0;
      Blue_W      <= 1'b0;
      Red_W       <= 1'b0;
      Blue_Score  <= '0;
      Red_Score   <= '0;
      Countdown   <= 2'd0;
    end else begin
      state       <= state_nxt;
      blue_won    <= blue_won_nxt;
      Move_En     <= (state_nxt == ST_PLAY);
      Reset_Round <= rr_nxt;
      Blue_W      <= (state_nxt == ST_MATCH_END) && blue_won_nxt;
      Red_W       <= (state_nxt == ST_MATCH_END) && !blue_won_nxt;
      Blue_Score  <= blue_nxt;
      Red_Score   <= red_nxt;
      Countdown   <= (state_nxt == ST_COUNTDOWN) ? countdown_sec(cnt_nxt, COUNT_FRAMES) : 2'd0;
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: cycle vector table with a scoreboard queue, plus
// hand sequences for the Reset_Round pulse window and the optional timeout.
module tb_round_controller;
  import tron_pkg::*;

  localparam int CF = 6;
  localparam int EF = 4;
  localparam int WS = 3;
  localparam int TF = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Frame_Tick = 1'b0;
  logic [2:0] Game_State = 3'd0;
  logic       Blue_Crash = 1'b0;
  logic       Red_Crash = 1'b0;
  logic       Move_En, Reset_Round, Blue_W, Red_W;
  logic [3:0] Blue_Score, Red_Score;
  logic [1:0] Countdown;

  always #5 Clk = ~Clk;

  round_controller #(
    .COUNT_FRAMES(CF), .END_FRAMES(EF), .WIN_SCORE(WS), .TIMEOUT_FRAMES(TF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Frame_Tick(Frame_Tick), .Game_State(Game_State),
    .Blue_Crash(Blue_Crash), .Red_Crash(Red_Crash), .Move_En(Move_En),
    .Reset_Round(Reset_Round), .Blue_W(Blue_W), .Red_W(Red_W),
    .Blue_Score(Blue_Score), .Red_Score(Red_Score), .Countdown(Countdown)
  );

  typedef struct packed {
    logic       me, rr, bw, rw;
    logic [3:0] bs, rs;
    logic [1:0] cd;
  } out_t;

  typedef struct {
    string name;
    int    rst, gs, tick, b, r;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic out_t o(int me, int rr, int bw, int rw, int bs, int rs, int cd);
    out_t x;
    x.me = (me != 0); x.rr = (rr != 0); x.bw = (bw != 0); x.rw = (rw != 0);
    x.bs = 4'(bs); x.rs = 4'(rs); x.cd = 2'(cd);
    return x;
  endfunction

  function automatic void add(string nm, int rst, int gs, int tick, int b, int r, out_t e);
    vec_t v;
    v.name = nm; v.rst = rst; v.gs = gs; v.tick = tick; v.b = b; v.r = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Six countdown ticks after the load cycle: remaining 5,4,3,2,1 then PLAY.
  function automatic void add_countdown(string nm, int bs, int rs);
    int cds[5];
    cds = '{3, 2, 2, 1, 1};
    for (int k = 0; k < 5; k++) add($sformatf("%s_t%0d", nm, k + 1), 0, 2, 1, 0, 0, o(0, 0, 0, 0, bs, rs, cds[k]));
    add($sformatf("%s_t6", nm), 0, 2, 1, 0, 0, o(1, 0, 0, 0, bs, rs, 0));
  endfunction

  function automatic void add_end(string nm, int bs, int rs);
    for (int k = 0; k < EF - 1; k++) add($sformatf("%s_t%0d", nm, k + 1), 0, 2, 1, 0, 0, o(0, 0, 0, 0, bs, rs, 0));
    add($sformatf("%s_rr", nm), 0, 2, 1, 0, 0, o(0, 1, 0, 0, bs, rs, 0));
  endfunction

  function automatic out_t cur();
    return o(int'(Move_En), int'(Reset_Round), int'(Blue_W), int'(Red_W),
             int'(Blue_Score), int'(Red_Score), int'(Countdown));
  endfunction

  task automatic step(input int rst, input int gs, input int tick, input int b, input int r);
    @(negedge Clk);
    Reset = (rst != 0); Game_State = 3'(gs); Frame_Tick = (tick != 0);
    Blue_Crash = (b != 0); Red_Crash = (r != 0);
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 2, 1, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t exp_o, act_o;
    int   pulses, tick_cnt, ticks_at_pulse;

    add("reset",      1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("idle",       0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("start",      0, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add("cd_hold",    0, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add("cd_tick1",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add("cd_crash",   0, 2, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 3));
    add("cd_tick2",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 2));
    add("cd_gap",     0, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 2));
    add("cd_tick3",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 2));
    add("cd_tick4",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1));
    add("cd_tick5",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1));
    add("cd_tick6",   0, 2, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0));
    add("play",       0, 2, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0));
    add("red_crash",  0, 2, 0, 0, 1, o(0, 0, 0, 0, 1, 0, 0));
    add("crash_held", 0, 2, 0, 0, 1, o(0, 0, 0, 0, 1, 0, 0));
    add_end("end1", 1, 0);
    add("restart2",   0, 2, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 3));
    add_countdown("cd2", 1, 0);
    add("draw",       0, 2, 0, 1, 1, o(0, 0, 0, 0, 1, 0, 0));
    add_end("end2", 1, 0);
    add("restart3",   0, 2, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 3));
    add_countdown("cd3", 1, 0);
    add("blue_crash", 0, 2, 0, 1, 0, o(0, 0, 0, 0, 1, 1, 0));
    add_end("end3", 1, 1);
    add("restart4",   0, 2, 0, 0, 0, o(0, 0, 0, 0, 1, 1, 3));
    add_countdown("cd4", 1, 1);
    add("red_crash2", 0, 2, 0, 0, 1, o(0, 0, 0, 0, 2, 1, 0));
    add_end("end4", 2, 1);
    add("restart5",   0, 2, 0, 0, 0, o(0, 0, 0, 0, 2, 1, 3));
    add_countdown("cd5", 2, 1);
    add("blue_win",   0, 2, 0, 0, 1, o(0, 0, 1, 0, 3, 1, 0));
    add("match_hold", 0, 2, 0, 0, 0, o(0, 0, 1, 0, 3, 1, 0));
    add("gs_bluewin", 0, 3, 0, 0, 0, o(0, 0, 0, 0, 3, 1, 0));
    add("bw_hold",    0, 3, 1, 0, 1, o(0, 0, 0, 0, 3, 1, 0));
    add("menu_clear", 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("start6",     0, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add_countdown("cd6", 0, 0);
    add("red_crash6", 0, 2, 0, 0, 1, o(0, 0, 0, 0, 1, 0, 0));
    add_end("end6", 1, 0);
    add("restart7",   0, 2, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 3));
    add_countdown("cd7", 1, 0);
    add("play7",      0, 2, 0, 0, 0, o(1, 0, 0, 0, 1, 0, 0));
    add("reset_play", 1, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("post_reset", 0, 2, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add("pr_tick1",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 3));
    add("pr_tick2",   0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 2));
    add("paused",     0, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("paused_t1",  0, 1, 1, 0, 1, o(0, 0, 0, 0, 0, 0, 0));
    add("paused_t2",  0, 1, 1, 1, 0, o(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].exp);
      step(vecs[i].rst, vecs[i].gs, vecs[i].tick, vecs[i].b, vecs[i].r);
      exp_o = sb.pop_front();
      act_o = cur();
      n_checks++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL %s: got me=%0b rr=%0b bw=%0b rw=%0b bs=%0d rs=%0d cd=%0d, expected me=%0b rr=%0b bw=%0b rw=%0b bs=%0d rs=%0d cd=%0d",
                 vecs[i].name, act_o.me, act_o.rr, act_o.bw, act_o.rw, act_o.bs, act_o.rs, act_o.cd,
                 exp_o.me, exp_o.rr, exp_o.bw, exp_o.rw, exp_o.bs, exp_o.rs, exp_o.cd);
      end
    end

    // Reset_Round window: exactly one pulse, right after the END_FRAMES-th tick.
    step(0, 2, 0, 0, 0);
    ticks(CF);
    chk("hs_play", int'(Move_En), 1);
    step(0, 2, 0, 0, 1);
    chk("hs_score", int'(Blue_Score), 1);
    pulses = 0; tick_cnt = 0; ticks_at_pulse = -1;
    for (int i = 0; i < 16; i++) begin
      step(0, 2, (i % 2 == 0) ? 1 : 0, 0, 0);
      if (i % 2 == 0) tick_cnt++;
      if (Reset_Round) begin
        pulses++;
        ticks_at_pulse = tick_cnt;
      end
    end
    chk("hs_rr_pulses", pulses, 1);
    chk("hs_rr_tick", ticks_at_pulse, EF);
    step(0, 0, 0, 0, 0);
    chk("hs_menu_score", int'(Blue_Score), 0);
    chk("hs_menu_cd", int'(Countdown), 0);

`ifdef ROUND_TIMEOUT_EN
    step(0, 2, 0, 0, 0);
    ticks(CF);
    chk("to_play", int'(Move_En), 1);
    for (int k = 0; k < TF - 1; k++) begin
      step(0, 2, 1, 0, 0);
      step(0, 2, 0, 0, 0);
    end
    chk("to_before", int'(Move_En), 1);
    step(0, 2, 1, 0, 0);
    chk("to_expire", int'(Move_En), 0);
    chk("to_scores", int'(Blue_Score) + int'(Red_Score), 0);
    ticks(EF - 1);
    chk("to_no_rr", int'(Reset_Round), 0);
    ticks(1);
    chk("to_rr", int'(Reset_Round), 1);
    step(0, 2, 0, 0, 0);
    ticks(CF);
    chk("to_play2", int'(Move_En), 1);
    ticks(TF - 1);
    step(0, 2, 1, 0, 1);
    chk("to_crash_prio", int'(Blue_Score), 1);
    chk("to_crash_me", int'(Move_En), 0);
    step(0, 0, 0, 0, 0);
`else
    step(0, 2, 0, 0, 0);
    ticks(CF);
    chk("nt_play", int'(Move_En), 1);
    ticks(TF + 2);
    chk("no_timeout", int'(Move_En), 1);
    chk("nt_scores", int'(Blue_Score) + int'(Red_Score), 0);
    step(0, 1, 0, 0, 0);
    chk("nt_leave", int'(Move_En), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
